// File: rtl/ram_pkg.sv
// Shared types and the byte-merge helper for the ram_be_clr storage bank.
// The helper works on a fixed maximum width; callers widen/truncate to their own DATA_W.
package ram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } ram_state_t;

   localparam int MAX_DATA_W = 256;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   // Replace only the bytes selected by be; unselected bytes keep old_w.
   function automatic logic [MAX_DATA_W-1:0] byte_merge(
      input logic [MAX_DATA_W-1:0] old_w,
      input logic [MAX_DATA_W-1:0] new_w,
      input logic [MAX_BE_W-1:0]   be_w
   );
      logic [MAX_DATA_W-1:0] res;
      res = old_w;
      for (int i = 0; i < MAX_BE_W; i++) begin
         if (be_w[i]) begin
            res[8*i +: 8] = new_w[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ram_array.sv
// Storage array only: byte-masked synchronous write and registered read, no reset.
// Address range checks and clear sequencing live in the top level.
module ram_array
   import ram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32,
   localparam int BE_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [BE_W-1:0]   be_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdat_i,
   output logic [DATA_W-1:0] rdat_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdat_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= DATA_W'(byte_merge(MAX_DATA_W'(mem_q[addr_i]),
                                             MAX_DATA_W'(wdat_i),
                                             MAX_BE_W'(be_i)));
      end
      if (re_i) begin
         rdat_q <= mem_q[addr_i];
      end
   end

   assign rdat_o = rdat_q;

endmodule

// File: rtl/ram_be_clr.sv
// Parametrised single-port RAM with byte enables, registered read + valid strobe,
// range error pulse and a clear engine that zeroes the array after reset or on request.
module ram_be_clr
   import ram_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32,
   localparam int BE_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cen,
   input  logic              wen,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   input  logic [BE_W-1:0]   be,
   input  logic              clr_req,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              busy,
   output logic              err
);

   localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   ram_state_t        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              dv_q, dv_d;
   logic              err_q, err_d;
   logic              zero_q, zero_d;

   logic              in_range;
   logic              arr_we, arr_re;
   logic [ADDR_W-1:0] arr_addr;
   logic [DATA_W-1:0] arr_wdat;
   logic [BE_W-1:0]   arr_be;
   logic [DATA_W-1:0] arr_rdat;

   assign in_range = ({1'b0, addr} < DEPTH_W);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      dv_d     = 1'b0;
      err_d    = 1'b0;
      zero_d   = zero_q;
      arr_we   = 1'b0;
      arr_re   = 1'b0;
      arr_addr = addr;
      arr_wdat = din;
      arr_be   = be;

      case (state_q)
         IDLE: begin
            if (cen) begin
               err_d = !in_range;
               if (wen) begin
                  arr_we = in_range;
               end else begin
                  // Out-of-range reads still strobe valid, but present zero data.
                  dv_d   = 1'b1;
                  zero_d = !in_range;
                  arr_re = in_range;
               end
            end
            if (clr_req) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         CLEAR: begin
            arr_we   = 1'b1;
            arr_addr = ptr_q;
            arr_wdat = '0;
            arr_be   = '1;
            ptr_d    = ptr_q + ADDR_W'(1);
            err_d    = cen;
            if (ptr_q == LAST) begin
               state_d = IDLE;
            end
         end
         default: state_d = CLEAR;
      endcase

      if (reset) begin
         arr_we = 1'b0;
         arr_re = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
         dv_q    <= 1'b0;
         err_q   <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         dv_q    <= dv_d;
         err_q   <= err_d;
         zero_q  <= zero_d;
      end
   end

   ram_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk    (clk),
      .we_i   (arr_we),
      .re_i   (arr_re),
      .be_i   (arr_be),
      .addr_i (arr_addr),
      .wdat_i (arr_wdat),
      .rdat_o (arr_rdat)
   );

   // zero_q masks the array output so dout reads 0 after reset and after an out-of-range read.
   assign dout       = zero_q ? '0 : arr_rdat;
   assign dout_valid = dv_q;
   assign err        = err_q;
   assign busy       = (state_q == CLEAR);

endmodule
